// File: rtl/mux_sweep_checker_if.sv
// Stimulus/response bundle between the mux4 sweep checker and the mux harness.
interface mux_sweep_checker_if #(
  parameter int unsigned CNT_W = 7
);
  logic             start;
  logic             abort;
  logic [5:0]       stim;
  logic             gf_out;
  logic             bfg_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] gf_err_cnt;
  logic [CNT_W-1:0] bfg_err_cnt;
  logic [CNT_W-1:0] diff_cnt;
  logic             first_fail_valid;
  logic [5:0]       first_fail_vec;

  // Harness / controller side: issues start/abort, returns mux outputs.
  modport master (
    output start, abort, gf_out, bfg_out,
    input  stim, busy, done, pass, gf_err_cnt, bfg_err_cnt, diff_cnt,
           first_fail_valid, first_fail_vec
  );

  // Checker side.
  modport slave (
    input  start, abort, gf_out, bfg_out,
    output stim, busy, done, pass, gf_err_cnt, bfg_err_cnt, diff_cnt,
           first_fail_valid, first_fail_vec
  );
endinterface

// File: rtl/mux_sweep_checker.sv
// Sweeps all 64 {s1,s0,i3..i0} vectors into two mux4 implementations,
// checks both against a golden mux4 and against each other.
module mux_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_sweep_checker_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state, state_nx;
  logic [3:0]       settle_cnt;
  logic [5:0]       stim_q;
  logic [CNT_W-1:0] gf_cnt, bfg_cnt, df_cnt;
  logic             ff_valid;
  logic [5:0]       ff_vec;

  logic             do_start, do_abort, do_sample;
  logic [3:0]       data;
  logic [1:0]       sel;
  logic             expected, gf_bad, bfg_bad, diff_bad, vec_fail;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic en);
    if (en && (c != '1)) return c + 1'b1;
    return c;
  endfunction

  // Golden mux4 from the registered stimulus, plus per-vector verdicts.
  always_comb begin
    data     = stim_q[3:0];
    sel      = stim_q[5:4];
    expected = data[sel];
    gf_bad   = (bus.gf_out  != expected);
    bfg_bad  = (bus.bfg_out != expected);
    diff_bad = (bus.gf_out  != bus.bfg_out);
    vec_fail = gf_bad | bfg_bad | diff_bad;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and datapath strobes; abort outranks start and sampling.
  always_comb begin
    state_nx  = state;
    do_start  = 1'b0;
    do_abort  = 1'b0;
    do_sample = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          do_start = 1'b1;
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          do_abort = 1'b1;
          state_nx = IDLE;
        end else if (settle_cnt == 4'd0) begin
          state_nx = SAMPLE;
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          do_abort = 1'b1;
          state_nx = IDLE;
        end else begin
          do_sample = 1'b1;
          state_nx  = (stim_q == 6'h3F) ? DONE : SETTLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stimulus, settle timer, error counters and first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_q     <= '0;
      settle_cnt <= '0;
      gf_cnt     <= '0;
      bfg_cnt    <= '0;
      df_cnt     <= '0;
      ff_valid   <= 1'b0;
      ff_vec     <= '0;
    end else if (do_start) begin
      stim_q     <= '0;
      settle_cnt <= SETTLE_LOAD;
      gf_cnt     <= '0;
      bfg_cnt    <= '0;
      df_cnt     <= '0;
      ff_valid   <= 1'b0;
      ff_vec     <= '0;
    end else if (do_abort) begin
      stim_q <= '0;
    end else if (state == SETTLE) begin
      if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
    end else if (do_sample) begin
      gf_cnt  <= sat_inc(gf_cnt,  gf_bad);
      bfg_cnt <= sat_inc(bfg_cnt, bfg_bad);
      df_cnt  <= sat_inc(df_cnt,  diff_bad);
      if (vec_fail && !ff_valid) begin
        ff_valid <= 1'b1;
        ff_vec   <= stim_q;
      end
      if (stim_q != 6'h3F) begin
        stim_q     <= stim_q + 6'd1;
        settle_cnt <= SETTLE_LOAD;
      end
    end
  end

  assign bus.stim             = stim_q;
  assign bus.busy             = (state == SETTLE) || (state == SAMPLE);
  assign bus.done             = (state == DONE);
  assign bus.pass             = (state == DONE) && (gf_cnt == '0) &&
                                (bfg_cnt == '0) && (df_cnt == '0);
  assign bus.gf_err_cnt       = gf_cnt;
  assign bus.bfg_err_cnt      = bfg_cnt;
  assign bus.diff_cnt         = df_cnt;
  assign bus.first_fail_valid = ff_valid;
  assign bus.first_fail_vec   = ff_vec;

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Bench for mux_sweep_checker: models both muxes with selectable faults and
// checks sweep results against hand-derived tables and a sweep-level model.
module tb_mux_sweep_checker;

  localparam int unsigned SC = 2;
  localparam int unsigned CW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_sweep_checker_if #(.CNT_W(CW)) bus ();

  mux_sweep_checker #(.SETTLE_CYCLES(SC), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Mux behaviours: 0 ideal, 1 stuck at 0, 2 I1/I2 swapped, 3 ideal xor mask.
  int          gf_mode  = 0;
  int          bfg_mode = 0;
  logic [63:0] gf_mask  = '0;
  logic [63:0] bfg_mask = '0;

  function automatic int golden(input int v);
    return (v >> (v / 16)) % 2;
  endfunction

  function automatic logic mux_resp(input int mode, input int v, input logic [63:0] mask);
    int s;
    int src;
    s = v / 16;
    case (mode)
      1: return 1'b0;
      2: begin
        src = (s == 1) ? 2 : (s == 2) ? 1 : s;
        return 1'((v >> src) % 2);
      end
      3: return 1'(golden(v)) ^ mask[v];
      default: return 1'(golden(v));
    endcase
  endfunction

  assign bus.gf_out  = mux_resp(gf_mode,  int'(bus.stim), gf_mask);
  assign bus.bfg_out = mux_resp(bfg_mode, int'(bus.stim), bfg_mask);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic longint all_outs();
    return longint'({bus.stim, bus.busy, bus.done, bus.pass, bus.gf_err_cnt,
                     bus.bfg_err_cnt, bus.diff_cnt, bus.first_fail_valid,
                     bus.first_fail_vec});
  endfunction

  // Sweep-level reference: walk all 64 vectors and tally the verdicts.
  task automatic model(output int e_gf, output int e_bfg, output int e_diff,
                       output int e_ffv, output int e_valid);
    int g, b, gd;
    e_gf = 0; e_bfg = 0; e_diff = 0; e_ffv = 0; e_valid = 0;
    for (int v = 0; v < 64; v++) begin
      gd = golden(v);
      g  = int'(mux_resp(gf_mode,  v, gf_mask));
      b  = int'(mux_resp(bfg_mode, v, bfg_mask));
      if (g != gd) e_gf++;
      if (b != gd) e_bfg++;
      if (g != b)  e_diff++;
      if ((g != gd || b != gd || g != b) && e_valid == 0) begin
        e_valid = 1;
        e_ffv   = v;
      end
    end
  endtask

  // Start a sweep and follow it to done, checking stim order and latency.
  task automatic run_sweep(input string tag);
    int n;
    int bad;
    int exp_stim;
    @(negedge clk);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    bad = 0;
    if (bus.stim != 6'd0 || !bus.busy) bad++;
    while (!bus.done && n < 400) begin
      tick();
      n++;
      exp_stim = n / (SC + 1);
      if (exp_stim > 63) exp_stim = 63;
      if (int'(bus.stim) != exp_stim) bad++;
      if (!bus.done && !bus.busy) bad++;
    end
    check({tag, "_latency"}, n, 64 * (SC + 1));
    check({tag, "_stim_seq"}, bad, 0);
  endtask

  typedef struct {
    int   gm, bm;
    int   e_gf, e_bfg, e_diff;
    int   e_ffv, e_valid, e_pass;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int e_gf, e_bfg, e_diff, e_ffv, e_valid;
    int n;

    tbl[0] = '{0, 0,  0,  0,  0, 8'h00, 0, 1};
    tbl[1] = '{0, 1,  0, 32, 32, 8'h01, 1, 0};
    tbl[2] = '{0, 2,  0, 16, 16, 8'h12, 1, 0};
    tbl[3] = '{1, 0, 32,  0, 32, 8'h01, 1, 0};
    tbl[4] = '{1, 1, 32, 32,  0, 8'h01, 1, 0};
    tbl[5] = '{2, 1, 16, 32, 32, 8'h01, 1, 0};

    bus.start = 1'b0;
    bus.abort = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick();
    check("idle_busy_done_stim", {bus.busy, bus.done, bus.stim}, 0);

    // Fault table.
    for (int i = 0; i < 6; i++) begin
      gf_mode  = tbl[i].gm;
      bfg_mode = tbl[i].bm;
      run_sweep($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_gf_cnt", i),  bus.gf_err_cnt,  tbl[i].e_gf);
      check($sformatf("tbl%0d_bfg_cnt", i), bus.bfg_err_cnt, tbl[i].e_bfg);
      check($sformatf("tbl%0d_diff", i),    bus.diff_cnt,    tbl[i].e_diff);
      check($sformatf("tbl%0d_ff", i), {bus.first_fail_valid, bus.first_fail_vec},
            {1'(tbl[i].e_valid), 6'(tbl[i].e_ffv)});
      check($sformatf("tbl%0d_pass_done", i), {bus.pass, bus.done}, {1'(tbl[i].e_pass), 1'b1});
    end

    // Done holds until the next start; start drops done/pass next cycle.
    gf_mode = 0; bfg_mode = 0;
    run_sweep("held");
    repeat (5) tick();
    check("done_held", {bus.done, bus.pass, bus.stim}, {2'b11, 6'h3F});
    @(negedge clk);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart_clears_done", {bus.done, bus.pass, bus.busy, bus.stim}, {3'b001, 6'h00});
    n = 0;
    while (!bus.done && n < 400) begin tick(); n++; end
    check("restart_latency", n, 64 * (SC + 1));

    // Random fault masks against the sweep-level model.
    for (int r = 0; r < 5; r++) begin
      gf_mode  = 3;
      bfg_mode = 3;
      gf_mask  = {$urandom, $urandom} & {$urandom, $urandom};
      bfg_mask = (r == 0) ? gf_mask : ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      if (r == 4) begin gf_mask = '0; bfg_mask = 64'h1 << $urandom_range(63); end
      model(e_gf, e_bfg, e_diff, e_ffv, e_valid);
      run_sweep($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_gf_cnt", r),  bus.gf_err_cnt,  e_gf);
      check($sformatf("rnd%0d_bfg_cnt", r), bus.bfg_err_cnt, e_bfg);
      check($sformatf("rnd%0d_diff", r),    bus.diff_cnt,    e_diff);
      check($sformatf("rnd%0d_ff", r), {bus.first_fail_valid, bus.first_fail_vec},
            {1'(e_valid), 6'(e_ffv)});
      check($sformatf("rnd%0d_pass", r), bus.pass,
            (e_gf == 0 && e_bfg == 0 && e_diff == 0) ? 1 : 0);
    end

    // Mid-sweep start ignored, then start+abort at stim 0x20 (abort wins).
    gf_mode = 0; bfg_mode = 1;
    @(negedge clk);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    e_ffv = 0;
    while (n < 96) begin
      tick();
      n++;
      if (n == 40) bus.start = 1'b1;
      if (n == 41) bus.start = 1'b0;
      if (int'(bus.stim) != n / (SC + 1) || !bus.busy) e_ffv++;
    end
    check("midstart_stim_seq", e_ffv, 0);
    check("stim_at_abort_point", bus.stim, 6'h20);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("abort_ctrl", {bus.busy, bus.done, bus.pass, bus.stim}, 0);
    check("abort_retained", {bus.gf_err_cnt, bus.bfg_err_cnt, bus.diff_cnt,
                             bus.first_fail_valid, bus.first_fail_vec},
          {7'd0, 7'd16, 7'd16, 1'b1, 6'h01});
    repeat (5) tick();
    check("abort_stays_idle", {bus.busy, bus.done, bus.stim}, 0);
    gf_mode = 0; bfg_mode = 0;
    @(negedge clk);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart_cleared", {bus.bfg_err_cnt, bus.diff_cnt, bus.first_fail_valid}, 0);
    n = 0;
    while (!bus.done && n < 400) begin tick(); n++; end
    check("post_abort_sweep", {bus.done, bus.pass, 9'(n)}, {2'b11, 9'(64 * (SC + 1))});

    // Abort landing on a SAMPLE cycle discards that vector's result.
    bfg_mode = 1;
    @(negedge clk);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_sample_discard", {bus.busy, bus.stim, bus.bfg_err_cnt, bus.diff_cnt,
                                   bus.first_fail_valid}, 0);

    // Asynchronous reset mid-sweep at stim 0x2A.
    bfg_mode = 2;
    @(negedge clk);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (42 * (SC + 1)) tick();
    check("stim_before_reset", bus.stim, 6'h2A);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick();
    check("post_reset_idle", all_outs(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sweep_checker.md
Name: mux_sweep_checker

Overview:
- Self-checking stimulus/response stage wrapped around the mux4 comparison harness (standard-cell mux4 alongside the generated BFG mux).
- Drives all 64 combinations of {s1,s0,i3,i2,i1,i0} into both muxes, waits for them to settle, then samples both outputs.
- Compares each output against a golden mux4 model and against each other, and reports error counts, the first failing vector and a pass/done summary.
- Upstream of both muxes (stimulus) and downstream of them (response checking).

Parameters:
- SETTLE_CYCLES, 2, cycles spent in SETTLE per vector; legal range 1..15.
- CNT_W, 7, width of each error counter; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; honoured only in IDLE or DONE.
- abort  input  1  stop the sweep; honoured only in SETTLE or SAMPLE.
- stim  output  6  registered vector: [0]=i0, [1]=i1, [2]=i2, [3]=i3, [4]=s0, [5]=s1.
- gf_out  input  1  standard-cell mux output.
- bfg_out  input  1  BFG mux output.
- busy  output  1  sweep in progress (SETTLE or SAMPLE).
- done  output  1  sweep complete; held until the next start.
- pass  output  1  done and all three counters are zero.
- gf_err_cnt  output  CNT_W  count of vectors with gf_out != expected.
- bfg_err_cnt  output  CNT_W  count of vectors with bfg_out != expected.
- diff_cnt  output  CNT_W  count of vectors with gf_out != bfg_out.
- first_fail_valid  output  1  at least one failing vector recorded.
- first_fail_vec  output  6  stim value of the first failing vector.

Behaviour:
- Reset (asynchronous, takes effect mid-operation too):
  - state = IDLE.
  - stim = 0; all counters = 0; first_fail_vec = 0.
  - busy, done, pass and first_fail_valid = 0.
- Golden model: sel = {stim[5],stim[4]}; expected = stim[sel].
  - Computed from the registered stim only; no dependency on the DUT.
- FSM state IDLE:
  - On start: clear counters, first_fail_valid and first_fail_vec; stim = 0; load settle counter; go to SETTLE.
- FSM state SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles, then go to SAMPLE. stim holds.
- FSM state SAMPLE:
  - Lasts one cycle. gf_out and bfg_out are sampled combinationally at this cycle's edge.
  - A vector fails if any of gf mismatch, bfg mismatch or diff holds.
  - Each applicable counter increments by 1, saturating at 2^CNT_W-1.
  - On the first failure, latch first_fail_vec = stim and set first_fail_valid; later failures do not overwrite it.
  - If stim == 63: go to DONE. Otherwise stim = stim+1, reload the settle counter and go to SETTLE (no wrap).
- FSM state DONE:
  - done = 1; pass = (all counters == 0).
  - stim holds at 63.
  - start restarts the sweep exactly as from IDLE; done and pass drop on the next cycle.
- abort in SETTLE or SAMPLE:
  - Go to IDLE; stim = 0.
  - Counters and first_fail fields are retained; done and pass stay 0.
  - Results from a SAMPLE cycle that coincides with abort are discarded.
- start while busy is ignored. If start and abort are asserted together, abort wins.
- busy = (state is SETTLE or SAMPLE).
- Sweep length: 64*(SETTLE_CYCLES+1) cycles. Vector k is sampled at cycle (k+1)*(SETTLE_CYCLES+1), counting the cycle in which start is sampled as cycle 0. done rises one cycle after the last SAMPLE.

Test Plan:
- Reset check: hold rst_n = 0, toggle clk -> all outputs zero; release rst_n, idle 10 cycles -> busy = 0, done = 0, stim = 0.
- Ideal DUT (both outputs = golden mux, SETTLE_CYCLES = 2): start at cycle 0 -> vector k sampled at cycle 3+3k, done = 1 at cycle 193, pass = 1, all counts 0, first_fail_valid = 0.
- bfg_out stuck at 0, gf ideal -> bfg_err_cnt = 32, diff_cnt = 32, gf_err_cnt = 0, first_fail_vec = 6'h01, pass = 0.
- bfg_out with I1/I2 swapped, gf ideal -> bfg_err_cnt = 16, diff_cnt = 16, gf_err_cnt = 0, first_fail_vec = 6'h12.
- start pulsed mid-sweep -> ignored, stim continues in sequence. abort at stim = 6'h20 -> IDLE with stim = 0, busy = 0, done = 0, counters retained. New start -> counters cleared, full sweep completes.
- rst_n low for 1 cycle while stim = 6'h2A -> all outputs clear immediately (asynchronously); FSM returns to IDLE and no sweep runs until start.
